// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key-schedule engine: one 32-bit schedule word per
// clock, complete 128-bit round keys handed out over a valid/ready handshake.

module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] INV_EXP = 8'hfe;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (INV_EXP[k]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv  = gf_inv(din);
  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_data,
  output logic [3:0]          rk_index,
  output logic                done
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [2:0] NK_M1   = 3'(NK - 1);
  localparam logic       IS_K256 = (NK == 8);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t state_reg, state_next;

  logic [31:0]  win_reg [NK];
  logic [31:0]  acc_reg [3];
  logic [5:0]   i_reg;
  logic [2:0]   j_reg;
  logic [7:0]   rcon_reg;
  logic [127:0] rk_data_reg;
  logic [3:0]   rk_index_reg;
  logic         rk_valid_reg;
  logic         done_reg;

  logic        completing;
  logic        accept;
  logic        stall;
  logic        advance;
  logic        in_key_phase;
  logic        rot_step;
  logic        sub_step;
  logic [31:0] temp;
  logic [31:0] rot_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] new_word;

  // Only a group-completing word needs the output register, so only it stalls.
  assign completing   = (i_reg[1:0] == 2'd3);
  assign accept       = rk_valid_reg && rk_ready;
  assign stall        = completing && rk_valid_reg && !rk_ready;
  assign advance      = (state_reg == RUN) && !stall;
  assign in_key_phase = (i_reg < NK_W);
  assign rot_step     = !in_key_phase && (j_reg == 3'd0);
  assign sub_step     = !in_key_phase && IS_K256 && (j_reg == 3'd4);

  assign temp     = win_reg[NK-1];
  assign rot_word = {temp[23:0], temp[31:24]};
  assign sub_in   = rot_step ? rot_word : temp;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .din  (sub_in[8*gi +: 8]),
        .dout (sub_out[8*gi +: 8])
      );
    end
  endgenerate

  // win_reg[0] is w[i-NK]; during the key phase the window just rotates.
  always_comb begin
    new_word = win_reg[0] ^ temp;
    if (in_key_phase) begin
      new_word = win_reg[0];
    end else if (rot_step) begin
      new_word = win_reg[0] ^ sub_out ^ {rcon_reg, 24'h000000};
    end else if (sub_step) begin
      new_word = win_reg[0] ^ sub_out;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (advance && (i_reg == LAST_W)) state_next = FINISH;
      FINISH:  if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) win_reg[k] <= 32'h0;
      for (int k = 0; k < 3; k++) acc_reg[k] <= 32'h0;
      i_reg        <= 6'd0;
      j_reg        <= 3'd0;
      rcon_reg     <= 8'h01;
      rk_data_reg  <= 128'h0;
      rk_index_reg <= 4'd0;
      rk_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state_reg == FINISH) && accept;

      if ((state_reg == IDLE) && start) begin
        for (int k = 0; k < NK; k++) win_reg[k] <= key_in[KEY_BITS-1-32*k -: 32];
        i_reg    <= 6'd0;
        j_reg    <= 3'd0;
        rcon_reg <= 8'h01;
      end else if (advance) begin
        for (int k = 0; k < NK - 1; k++) win_reg[k] <= win_reg[k+1];
        win_reg[NK-1] <= new_word;
        i_reg <= i_reg + 6'd1;
        j_reg <= (j_reg == NK_M1) ? 3'd0 : j_reg + 3'd1;
        if (rot_step) rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
        for (int k = 0; k < 3; k++) begin
          if (!completing && (i_reg[1:0] == 2'(k))) acc_reg[k] <= new_word;
        end
      end

      if (advance && completing) begin
        rk_data_reg  <= {acc_reg[0], acc_reg[1], acc_reg[2], new_word};
        rk_index_reg <= i_reg[5:2];
        rk_valid_reg <= 1'b1;
      end else if (accept) begin
        rk_valid_reg <= 1'b0;
      end
    end
  end

  assign busy     = (state_reg != IDLE);
  assign rk_valid = rk_valid_reg;
  assign rk_data  = rk_data_reg;
  assign rk_index = rk_index_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_aes_key_expander.sv
// Drives AES-128/192/256 expander instances and checks every round key against
// a table-driven key-schedule model, including backpressure, abort and restart.

module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         rdy;
  logic [1:0]   sel;
  logic [255:0] key_drv;

  logic         busy_a, busy_b, busy_c;
  logic         valid_a, valid_b, valid_c;
  logic [127:0] data_a, data_b, data_c;
  logic [3:0]   idx_a, idx_b, idx_c;
  logic         done_a, done_b, done_c;

  logic         cur_busy, cur_valid, cur_done;
  logic [127:0] cur_data;
  logic [3:0]   cur_idx;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  int           got_n;

  always #5 clk = ~clk;

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(start && sel == 2'd0), .key_in(key_drv[255:128]),
    .busy(busy_a), .rk_valid(valid_a), .rk_ready(rdy), .rk_data(data_a),
    .rk_index(idx_a), .done(done_a)
  );

  aes_key_expander #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .start(start && sel == 2'd1), .key_in(key_drv[255:64]),
    .busy(busy_b), .rk_valid(valid_b), .rk_ready(rdy), .rk_data(data_b),
    .rk_index(idx_b), .done(done_b)
  );

  aes_key_expander #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start && sel == 2'd2), .key_in(key_drv),
    .busy(busy_c), .rk_valid(valid_c), .rk_ready(rdy), .rk_data(data_c),
    .rk_index(idx_c), .done(done_c)
  );

  always_comb begin
    cur_busy  = busy_a;
    cur_valid = valid_a;
    cur_data  = data_a;
    cur_idx   = idx_a;
    cur_done  = done_a;
    if (sel == 2'd1) begin
      cur_busy = busy_b; cur_valid = valid_b; cur_data = data_b; cur_idx = idx_b; cur_done = done_b;
    end else if (sel == 2'd2) begin
      cur_busy = busy_c; cur_valid = valid_c; cur_data = data_c; cur_idx = idx_c; cur_done = done_c;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < nk + 7; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One expansion: start, consume keys with a given ready probability, check all.
  task automatic run(input int nk, input int ready_pct, input bit check_spacing,
                     input bit inject, input int abort_at);
    int           nr;
    int           k;
    int           last_rise;
    bit           prev_v;
    bit           prev_r;
    bit           accepted_last;
    bit           finished;
    logic [127:0] prev_d;
    logic [3:0]   prev_i;
    nr = nk + 6;
    build_model(key_drv, nk);
    sel = (nk == 4) ? 2'd0 : (nk == 6) ? 2'd1 : 2'd2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = -1; got_n = 0; prev_v = 0; prev_r = 0; last_rise = 0;
    accepted_last = 0; finished = 0; prev_d = '0; prev_i = '0;
    while (!finished && k < 600) begin
      @(negedge clk);
      k++;
      if (accepted_last) begin
        chk("done_pulse", 128'(cur_done), 128'd1);
        chk("busy_after_done", 128'(cur_busy), 128'd0);
        finished = 1;
      end else begin
        chk("done_low", 128'(cur_done), 128'd0);
        if (k == 0) chk("busy_start", 128'(cur_busy), 128'd1);
        if (prev_v && !prev_r) begin
          chk("stall_valid", 128'(cur_valid), 128'd1);
          chk("stall_data", cur_data, prev_d);
          chk("stall_index", 128'(cur_idx), 128'(prev_i));
        end
        if (check_spacing) begin
          chk("valid_pulse", 128'(cur_valid && prev_v), 128'd0);
          if (cur_valid && !prev_v) begin
            chk("spacing", 128'(k - last_rise), 128'd4);
            last_rise = k;
          end
        end
        if (abort_at >= 0 && got_n == abort_at + 1) begin
          rst = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          chk("abort_busy", 128'(cur_busy), 128'd0);
          chk("abort_valid", 128'(cur_valid), 128'd0);
          chk("abort_index", 128'(cur_idx), 128'd0);
          chk("abort_data", cur_data, 128'd0);
          repeat (8) begin
            @(negedge clk);
            chk("abort_quiet", 128'(cur_valid), 128'd0);
          end
          return;
        end
        start = inject && (k == 6);
        if (inject && k == 6) key_drv = ~key_drv;
        rdy = ($urandom_range(99) < ready_pct);
        if (cur_valid && rdy) begin
          if (got_n <= nr) begin
            chk("rk_data", cur_data, exp_rk[got_n]);
            chk("rk_index", 128'(cur_idx), 128'(got_n));
            got_rk[got_n] = cur_data;
            got_n++;
            if (got_n == nr + 1) accepted_last = 1;
          end else begin
            chk("extra_key", 128'(got_n), 128'(nr));
            finished = 1;
          end
        end
        prev_v = cur_valid; prev_r = rdy; prev_d = cur_data; prev_i = cur_idx;
      end
    end
    start = 1'b0;
    chk("key_count", 128'(got_n), 128'(nr + 1));
    @(negedge clk);
    chk("done_once", 128'(cur_done), 128'd0);
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    rst = 1'b1; start = 1'b0; rdy = 1'b0; sel = 2'd0; key_drv = '0;

    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 128'({busy_a, busy_b, busy_c}), 128'd0);
    chk("reset_valid", 128'({valid_a, valid_b, valid_c}), 128'd0);
    chk("reset_done", 128'({done_a, done_b, done_c}), 128'd0);
    chk("reset_data", data_a | data_b | data_c, 128'd0);
    chk("reset_index", 128'({idx_a, idx_b, idx_c}), 128'd0);
    rst = 1'b0;

    key_drv = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    run(4, 100, 1'b1, 1'b0, -1);
    chk("aes128_rk0", got_rk[0], 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    chk("aes128_rk1", got_rk[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("aes128_rk10", got_rk[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    key_drv = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
    run(6, 100, 1'b1, 1'b0, -1);
    chk("aes192_rk12", got_rk[12], 128'he98ba06f_448c773c_8ecc7204_01002202);

    key_drv = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    run(8, 100, 1'b1, 1'b0, -1);
    chk("aes256_rk14", got_rk[14], 128'hfe4890d1_e6188d0b_046df344_706c631e);

    key_drv = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    run(4, 30, 1'b0, 1'b0, -1);
    chk("bp_rk10", got_rk[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 8; w++) key_drv[32*w +: 32] = $urandom;
      run(4 + 2 * (n % 3), 50, 1'b0, 1'b0, -1);
    end

    for (int w = 0; w < 8; w++) key_drv[32*w +: 32] = $urandom;
    run(4, 100, 1'b1, 1'b1, -1);

    key_drv = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
    run(4, 100, 1'b0, 1'b0, 3);
    key_drv = '0;
    run(4, 100, 1'b1, 1'b0, -1);
    chk("zero_key_rk1", got_rk[1], 128'h62636363_62636363_62636363_62636363);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Iterative, parametrised AES key-schedule engine covering AES-128, AES-192 and AES-256. It generates one 32-bit schedule word per clock and emits complete 128-bit round keys over a valid/ready handshake. It feeds the sequential cipher datapath and replaces per-round combinational key generation. Its SubWord step uses four instances of the existing sbox module (8-bit in, 8-bit out).

Parameters:
KEY_BITS, 128, cipher key length; legal values 128/192/256, any other value is an elaboration error.
NK (derived), KEY_BITS/32, key length in words: 4/6/8.
NR (derived), NK+6, number of rounds: 10/12/14.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-high.
start  in  1  begin an expansion of key_in; sampled only in IDLE.
key_in  in  KEY_BITS  cipher key; word 0 = key_in[KEY_BITS-1:KEY_BITS-32].
busy  out  1  high from the start edge until done.
rk_valid  out  1  rk_data/rk_index valid.
rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready.
rk_data  out  128  round key; w[4r] in [127:96] through w[4r+3] in [31:0].
rk_index  out  4  round number r, 0..NR.
done  out  1  one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset: state=IDLE; busy, rk_valid, done=0; rk_data=0; rk_index=0; rcon=8'h01; word counter i=0. Reset mid-expansion aborts immediately, with no further rk_valid.
- States: IDLE -> RUN on start. RUN -> FINISH after word 4(NR+1)-1 is generated. FINISH -> IDLE on the edge where round key NR is accepted; done pulses in the following cycle.
- start while busy is ignored. key_in is captured on the start edge only.
- Word generation: one word w[i] per cycle in RUN, i = 0 .. 4(NR+1)-1.
  - i<NK: w[i] = key word i.
  - Otherwise, with temp = w[i-1]:
    - i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon) (left shift, XOR 8'h1b if bit 7 was set).
    - NK==8 and i mod NK == 4: temp = SubWord(temp).
    - w[i] = w[i-NK] ^ temp.
- RotWord: {b1,b2,b3,b0}. SubWord: sbox applied per byte.
- Storage: a sliding window of the last NK words and a 3-word accumulator. There is no full-schedule RAM.
- Round-key output: the 4th word of a group, together with the 3 accumulated words, loads rk_data, sets rk_index = i/4 and sets rk_valid.
- Stall: if rk_valid && !rk_ready and the next word would complete a group, generation holds. The word counter, window and rcon are frozen. Non-completing words continue.
- With rk_ready held high: rk_valid rises 4 clocks after the start edge (round key 0), then every 4 clocks. rk_valid stays high only one cycle per key in that case.
- rk_data and rk_index remain stable while rk_valid && !rk_ready.
- rk_valid deasserts on acceptance unless a new key loads on the same edge.
- Total round keys: NR+1. In FINISH, no words are generated.
- Simultaneous start and rst: rst wins.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1 -> rk0 equals the key. rk1 = a0fafe17_88542cb1_23a33939_2a6c7605. rk10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6. Keys arrive 4 cycles apart; done pulses once; 11 keys total.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> rk12 = e98ba06f_448c773c_8ecc7204_01002202; 13 keys total.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> rk14 = fe4890d1_e6188d0b_046df344_706c631e; 15 keys total. Confirms the i mod 8 == 4 SubWord path.
- Backpressure: AES-128 vector with rk_ready random 30% high -> identical key sequence, rk_data/rk_index stable during stalls, no key lost or duplicated.
- rst asserted after rk3 and held 1 cycle -> busy and rk_valid are 0 the next cycle. A new start with an all-zero key -> rk1 = 62636363_62636363_62636363_62636363.
- start pulsed again while busy -> ignored; the key sequence matches the first start.
